// File: rtl/cmvn_seq.sv
// cmvn_seq: sequences feature samples through an external CMVN datapath into the normalized buffer.
// Optional WAIT-state timeout with err pulse enabled by defining CMVN_SEQ_TIMEOUT_EN.
module cmvn_seq #(
    parameter int NUM_COEF   = 20,
    parameter int MAX_FRAMES = 50,
    parameter int CMVN_LAT   = 3,
    parameter int TIMEOUT    = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [5:0]  num_frames,
    output logic        feat_rd_en,
    output logic [9:0]  feat_rd_addr,
    input  logic [31:0] feat_rd_data,
    output logic        cmvn_en,
    output logic [31:0] cmvn_data,
    output logic [4:0]  cmvn_addr,
    input  logic [31:0] cmvn_out_data,
    input  logic        cmvn_out_valid,
    output logic        norm_wr_en,
    output logic [9:0]  norm_wr_addr,
    output logic [31:0] norm_wr_data,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam int CW   = $clog2(NUM_COEF);
    localparam int WMAX = TIMEOUT > CMVN_LAT ? TIMEOUT : CMVN_LAT;
    localparam int WW   = $clog2(WMAX + 1);
    localparam logic [WW-1:0] LAT_M1 = WW'(CMVN_LAT - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, ISSUE, WAIT, WRITE, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] coef_q, coef_d;
    logic [5:0]    frame_q, frame_d, frames_q, frames_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [31:0]   data_q, data_d, res_q, res_d;
    logic [4:0]    caddr_q, caddr_d;
    logic          lat_ok, exit_ok, last_coef, timeout_hit;
    logic [9:0]    addr;

    assign lat_ok    = wait_q >= LAT_M1;
    assign exit_ok   = lat_ok && cmvn_out_valid;
    assign last_coef = coef_q == CW'(NUM_COEF - 1);
    assign addr      = 10'(frame_q) * 10'(NUM_COEF) + 10'(coef_q);
`ifdef CMVN_SEQ_TIMEOUT_EN
    localparam logic [WW-1:0] TO_M1 = WW'(TIMEOUT - 1);
    assign timeout_hit = state_q == WAIT && !exit_ok && wait_q >= TO_M1;
`else
    assign timeout_hit = 1'b0;
`endif

    // next-state and datapath register updates; abort overrides every other transition
    always_comb begin
        state_d  = state_q;
        coef_d   = coef_q;
        frame_d  = frame_q;
        frames_d = frames_q;
        wait_d   = wait_q;
        data_d   = data_q;
        res_d    = res_q;
        caddr_d  = caddr_q;
        case (state_q)
            IDLE: if (start) begin
                frames_d = num_frames > 6'(MAX_FRAMES) ? 6'(MAX_FRAMES) : num_frames;
                coef_d   = '0;
                frame_d  = '0;
                state_d  = FETCH;
            end
            FETCH: state_d = frames_q == '0 ? DONE : LOAD;
            LOAD: begin
                data_d  = feat_rd_data;
                caddr_d = 5'(coef_q);
                state_d = ISSUE;
            end
            ISSUE: begin
                wait_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                wait_d  = wait_q == '1 ? wait_q : wait_q + WW'(1);
                res_d   = exit_ok ? cmvn_out_data : res_q;
                state_d = exit_ok ? WRITE : timeout_hit ? IDLE : WAIT;
            end
            WRITE: begin
                coef_d  = last_coef ? '0 : coef_q + CW'(1);
                frame_d = last_coef ? frame_q + 6'd1 : frame_q;
                state_d = (last_coef && frame_q == frames_q - 6'd1) ? DONE : FETCH;
            end
            default: state_d = IDLE;
        endcase
        if (abort && state_q != IDLE) state_d = IDLE;
    end

    // state and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            coef_q   <= '0;
            frame_q  <= '0;
            frames_q <= '0;
            wait_q   <= '0;
            data_q   <= '0;
            res_q    <= '0;
            caddr_q  <= '0;
        end else begin
            state_q  <= state_d;
            coef_q   <= coef_d;
            frame_q  <= frame_d;
            frames_q <= frames_d;
            wait_q   <= wait_d;
            data_q   <= data_d;
            res_q    <= res_d;
            caddr_q  <= caddr_d;
        end
    end

    assign busy         = state_q != IDLE;
    assign feat_rd_en   = state_q == FETCH && frames_q != '0;
    assign feat_rd_addr = addr;
    assign cmvn_en      = state_q == ISSUE;
    assign cmvn_data    = data_q;
    assign cmvn_addr    = caddr_q;
    assign norm_wr_en   = state_q == WRITE && !abort;
    assign norm_wr_addr = addr;
    assign norm_wr_data = res_q;
    assign done         = state_q == DONE && !abort;
    assign err          = timeout_hit && !abort;
endmodule

// File: tb/tb_cmvn_seq.sv
// tb_cmvn_seq: randomized self-checking bench for cmvn_seq against a queue-based job model.
module tb_cmvn_seq;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic [5:0]  num_frames = '0;
    logic        feat_rd_en, cmvn_en, norm_wr_en, busy, done, err, cmvn_out_valid;
    logic [9:0]  feat_rd_addr, norm_wr_addr;
    logic [31:0] feat_rd_data = '0, cmvn_data, norm_wr_data, cmvn_out_data;
    logic [4:0]  cmvn_addr;

    always #5 clk = ~clk;

    cmvn_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_frames(num_frames),
        .feat_rd_en(feat_rd_en), .feat_rd_addr(feat_rd_addr), .feat_rd_data(feat_rd_data),
        .cmvn_en(cmvn_en), .cmvn_data(cmvn_data), .cmvn_addr(cmvn_addr),
        .cmvn_out_data(cmvn_out_data), .cmvn_out_valid(cmvn_out_valid),
        .norm_wr_en(norm_wr_en), .norm_wr_addr(norm_wr_addr), .norm_wr_data(norm_wr_data),
        .busy(busy), .done(done), .err(err)
    );

    // feature buffer: one-cycle read latency, garbage when not read
    logic [31:0] mem [0:1023];
    always @(posedge clk) feat_rd_data <= feat_rd_en ? mem[feat_rd_addr] : 32'hbad0_bad0;

    // CMVN datapath: result = sample+1 after lat cycles, optional spurious early valids
    int          cyc = 0, lat = 3;
    bit          noise = 0, hold = 0, rand_lat = 0;
    logic [31:0] res = '0;
    logic [1:0]  nz = '0;
    always @(posedge clk) begin
        if (cmvn_en) begin
            cyc <= 1;
            res <= cmvn_data + 32'd1;
            lat <= rand_lat ? int'($urandom_range(3, 6)) : 3;
            nz  <= noise ? 2'($urandom) : 2'b00;
        end else if (cyc != 0 && cyc < 1000) cyc <= cyc + 1;
    end
    assign cmvn_out_valid = !hold && cyc != 0 && (cyc == lat || (cyc == 1 && nz[0]) || (cyc == 2 && nz[1]));
    assign cmvn_out_data  = cyc == lat ? res : 32'hdead_beef;

    logic [9:0]  exp_a [$];
    logic [31:0] exp_d [$];
    int          n_chk = 0, n_fail = 0, n_wr = 0, n_done = 0, n_err = 0, rd_idx = 0;
    logic [9:0]  last_rd = '0, last_wa = '0;
    logic [31:0] last_wd = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // compare process: every cycle out of reset, checked away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            chk("en_exclusive", 32'(feat_rd_en) + 32'(cmvn_en) + 32'(norm_wr_en) > 32'd1 ? 32'd1 : 32'd0, 32'd0);
            if (feat_rd_en) begin
                chk("rd_addr", 32'(feat_rd_addr), 32'(rd_idx));
                last_rd = feat_rd_addr;
                rd_idx++;
            end
            if (cmvn_en) begin
                chk("cmvn_addr", 32'(cmvn_addr), 32'(last_rd) % 32'd20);
                chk("cmvn_data", cmvn_data, mem[last_rd]);
            end
            if (norm_wr_en) begin
                n_wr++;
                last_wa = norm_wr_addr;
                last_wd = norm_wr_data;
                if (exp_a.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL wr_unexpected: got write addr %0d data %0h, expected none", norm_wr_addr, norm_wr_data);
                end else begin
                    chk("wr_addr", 32'(norm_wr_addr), 32'(exp_a.pop_front()));
                    chk("wr_data", norm_wr_data, exp_d.pop_front());
                end
            end
            if (done) begin
                n_done++;
                chk("busy_at_done", 32'(busy), 32'd1);
            end
            if (err) n_err++;
        end
    end

    task automatic load_model(input int nf);
        int n = (nf > 50 ? 50 : nf) * 20;
        exp_a.delete();
        exp_d.delete();
        for (int i = 0; i < n; i++) begin
            exp_a.push_back(10'(i));
            exp_d.push_back(mem[i] + 32'd1);
        end
        rd_idx = 0;
    endtask

    task automatic pulse_start(input int nf);
        @(posedge clk); #1 start = 1'b1; num_frames = 6'(nf);
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_job(input int nf, input bit poke, output int c);
        load_model(nf);
        pulse_start(nf);
        c = 0;
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk);
            c++;
            if (done) break;
            if (poke) begin start = 1'($urandom); num_frames = 6'($urandom); end
        end
        start = 1'b0;
        chk("done_seen", 32'(done), 32'd1);
        chk("model_drained", 32'(exp_a.size()), 32'd0);
        @(negedge clk);
        chk("busy_after_done", 32'(busy), 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {26'd0, busy, done, err, feat_rd_en, cmvn_en, norm_wr_en}, 32'd0);
        chk({tag, "_rd_addr"}, 32'(feat_rd_addr), 32'd0);
        chk({tag, "_wr_addr"}, 32'(norm_wr_addr), 32'd0);
        chk({tag, "_wr_data"}, norm_wr_data, 32'd0);
        chk({tag, "_cmvn_data"}, cmvn_data, 32'd0);
        chk({tag, "_cmvn_addr"}, 32'(cmvn_addr), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c, w0, d0, e0, nf;
        bit found;
        for (int i = 0; i < 1024; i++) mem[i] = 32'(i);
        #1 chk_zero("reset");
        @(negedge clk) rst_n = 1'b1;

        // single frame, fixed latency: 20 samples at 7 cycles each, done at 141
        w0 = n_wr; d0 = n_done;
        run_job(1, 0, c);
        chk("t1_cycles", 32'(c), 32'd141);
        chk("t1_writes", 32'(n_wr - w0), 32'd20);
        chk("t1_last_addr", 32'(last_wa), 32'd19);
        chk("t1_last_data", last_wd, 32'd20);
        chk("t1_done", 32'(n_done - d0), 32'd1);

        // two frames with start/num_frames noise while busy
        w0 = n_wr; d0 = n_done;
        run_job(2, 1, c);
        chk("t2_cycles", 32'(c), 32'd281);
        chk("t2_writes", 32'(n_wr - w0), 32'd40);
        chk("t2_last_addr", 32'(last_wa), 32'd39);
        chk("t2_done", 32'(n_done - d0), 32'd1);

        // zero frames: no memory traffic, done two cycles after start
        w0 = n_wr;
        run_job(0, 0, c);
        chk("t3_cycles", 32'(c), 32'd2);
        chk("t3_writes", 32'(n_wr - w0), 32'd0);
        chk("t3_reads", 32'(rd_idx), 32'd0);

        // random data, random latency, spurious early valids
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        rand_lat = 1; noise = 1;
        for (int j = 0; j < 4; j++) begin
            nf = int'($urandom_range(1, 3));
            w0 = n_wr;
            run_job(nf, 1, c);
            chk("rand_writes", 32'(n_wr - w0), 32'(nf * 20));
        end
        w0 = n_wr;
        run_job(63, 1, c);
        chk("t5_writes_clamped", 32'(n_wr - w0), 32'd1000);
        rand_lat = 0; noise = 0;

        // abort in WAIT of sample 5
        load_model(2);
        w0 = n_wr; d0 = n_done;
        pulse_start(2);
        found = 0;
        for (int k = 0; k < 2000 && !found; k++) begin
            @(negedge clk);
            found = cmvn_en && (n_wr - w0 == 5);
        end
        chk("abort_reached", 32'(found), 32'd1);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (40) @(negedge clk);
        chk("abort_writes", 32'(n_wr - w0), 32'd5);
        chk("abort_done", 32'(n_done - d0), 32'd0);
        w0 = n_wr;
        run_job(1, 0, c);
        chk("post_abort_cycles", 32'(c), 32'd141);
        chk("post_abort_writes", 32'(n_wr - w0), 32'd20);

        // CMVN never answers
        hold = 1;
        load_model(1);
        w0 = n_wr; e0 = n_err;
        pulse_start(1);
        found = 0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk);
            found = cmvn_en;
        end
        chk("hold_issue", 32'(found), 32'd1);
`ifdef CMVN_SEQ_TIMEOUT_EN
        c = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            c++;
            if (err) break;
        end
        chk("timeout_cycles", 32'(c), 32'd64);
        @(negedge clk);
        chk("timeout_busy", 32'(busy), 32'd0);
        chk("timeout_err_count", 32'(n_err - e0), 32'd1);
`else
        repeat (200) @(negedge clk);
        chk("hold_busy", 32'(busy), 32'd1);
        chk("hold_err_count", 32'(n_err - e0), 32'd0);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("hold_abort_busy", 32'(busy), 32'd0);
`endif
        chk("hold_writes", 32'(n_wr - w0), 32'd0);
        hold = 0;

        // asynchronous reset in the middle of a WRITE
        load_model(1);
        w0 = n_wr; d0 = n_done;
        pulse_start(1);
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            found = norm_wr_en;
        end
        chk("rst_write_seen", 32'(found), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk_zero("midrst");
        @(negedge clk) rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("midrst_idle", 32'(busy), 32'd0);
        chk("midrst_writes", 32'(n_wr - w0), 32'd1);
        chk("midrst_done", 32'(n_done - d0), 32'd0);
        w0 = n_wr;
        run_job(1, 0, c);
        chk("post_rst_cycles", 32'(c), 32'd141);
        chk("post_rst_writes", 32'(n_wr - w0), 32'd20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
